// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter.
//   uart_tx_state_t : transmitter frame state
//   UART_DATA_BITS  : payload bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: divides clk_i into UART bit periods.
//   clk_i      : system clock
//   rst_i      : asynchronous active-high reset
//   clear_i    : restart the bit period (counter to 0)
//   enable_i   : count while high
//   bit_tick_o : high on the last cycle of each bit period
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_baud_counter: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] r_cnt;

  assign bit_tick_o = enable_i && (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (enable_i) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_wb.sv
// uart_tx_wb: 8N1/8N2 UART transmitter behind a Wishbone pipelined device port.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   cyc_i   : Wishbone cycle valid
//   stb_i   : Wishbone strobe
//   dat_i   : byte to transmit
//   stall_o : holding register full while a request is presented
//   ack_o   : one-cycle ack, the cycle after each accept
//   tx_o    : serial line, idle high
//   busy_o  : a byte is held or a frame is in progress
// A one-entry holding register accepts the next byte while the current frame
// shifts, so consecutive frames run without an idle gap.
module uart_tx_wb
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic [7:0] dat_i,
  output logic       stall_o,
  output logic       ack_o,
  output logic       tx_o,
  output logic       busy_o
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_wb: CLKS_PER_BIT must be >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_wb: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_t r_state, w_state_next;
  logic [7:0] r_shift, w_shift_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic       r_stop_cnt, w_stop_cnt_next;
  logic [7:0] r_hold;
  logic       r_hold_valid;
  logic       r_ack;
  logic       r_tx, w_tx_next;
  logic       w_accept;
  logic       w_load;
  logic       w_baud_clear;
  logic       w_baud_en;
  logic       w_bit_tick;

  // Stall comes from the registered hold flag, so an accept can never
  // coincide with the FSM emptying the holding register.
  assign stall_o  = cyc_i & stb_i & r_hold_valid;
  assign w_accept = cyc_i & stb_i & ~r_hold_valid;
  assign ack_o    = r_ack;
  assign tx_o     = r_tx;
  assign busy_o   = r_hold_valid | (r_state != IDLE);

  assign w_baud_en = (r_state != IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (w_baud_clear),
    .enable_i  (w_baud_en),
    .bit_tick_o(w_bit_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_ack        <= 1'b0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_hold       <= dat_i;
        r_hold_valid <= 1'b1;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_tx       <= w_tx_next;
    end
  end

  // tx is registered from the next-state view, so the line changes on the
  // same edge the FSM enters the corresponding bit.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_tx_next       = r_tx;
    w_load          = 1'b0;
    w_baud_clear    = 1'b0;

    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (r_hold_valid) begin
          w_load          = 1'b1;
          w_baud_clear    = 1'b1;
          w_shift_next    = r_hold;
          w_bit_cnt_next  = '0;
          w_stop_cnt_next = 1'b0;
          w_state_next    = START;
          w_tx_next       = 1'b0;
        end
      end

      START: begin
        if (w_bit_tick) begin
          w_state_next = DATA;
          w_tx_next    = r_shift[0];
        end
      end

      DATA: begin
        if (w_bit_tick) begin
          if (r_bit_cnt == BIT_LAST) begin
            w_state_next    = STOP;
            w_stop_cnt_next = 1'b0;
            w_tx_next       = 1'b1;
          end else begin
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            w_tx_next      = r_shift[1];
          end
        end
      end

      STOP: begin
        if (w_bit_tick) begin
          if (r_stop_cnt == STOP_LAST) begin
            if (r_hold_valid) begin
              // Chain straight into the next start bit.
              w_load          = 1'b1;
              w_baud_clear    = 1'b1;
              w_shift_next    = r_hold;
              w_bit_cnt_next  = '0;
              w_stop_cnt_next = 1'b0;
              w_state_next    = START;
              w_tx_next       = 1'b0;
            end else begin
              w_state_next = IDLE;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_stop_cnt_next = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

endmodule
